// File: rtl/shot_clock_bcd.sv
// Two-digit BCD shot-clock countdown feeding sevenseg_mux, plus the free-running scan_en strobe.
// Optional build macro LEADING_ZERO_BLANK_EN blanks the tens digit (4'hF) whenever it is zero.
module shot_clock_bcd #(
  parameter int unsigned TICK_DIV   = 100_000_000,
  parameter int unsigned SCAN_DIV   = 100_000,
  parameter logic [3:0]  START_TENS = 4'd2,
  parameter logic [3:0]  START_ONES = 4'd4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pause,
  input  logic       reload,
  output logic [3:0] d1,
  output logic [3:0] d0,
  output logic       scan_en,
  output logic       running,
  output logic       expired
);

  localparam int unsigned TICK_W = $clog2(TICK_DIV);
  localparam int unsigned SCAN_W = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

  state_t              state;
  logic [3:0]          tens, ones;
  logic [3:0]          dec_tens, dec_ones;
  logic                dec_zero;
  logic [TICK_W-1:0]   tick_cnt;
  logic [SCAN_W-1:0]   scan_cnt;

  function automatic logic [3:0] map_d1(input logic [3:0] t);
`ifdef LEADING_ZERO_BLANK_EN
    return (t == 4'd0) ? 4'hF : t;
`else
    return t;
`endif
  endfunction

  // Saturating BCD decrement: 00 stays 00.
  always_comb begin
    dec_tens = tens;
    dec_ones = ones;
    if (ones != 4'd0) begin
      dec_ones = ones - 4'd1;
    end else if (tens != 4'd0) begin
      dec_ones = 4'd9;
      dec_tens = tens - 4'd1;
    end
    dec_zero = (dec_tens == 4'd0) && (dec_ones == 4'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      scan_en  <= 1'b0;
    end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      scan_en  <= 1'b1;
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
      scan_en  <= 1'b0;
    end
  end

  // d1/d0 are updated on the same edge as tens/ones so the display has no extra latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tens     <= START_TENS;
      ones     <= START_ONES;
      tick_cnt <= '0;
      d1       <= map_d1(START_TENS);
      d0       <= START_ONES;
      running  <= 1'b0;
      expired  <= 1'b0;
    end else if (reload) begin
      state    <= IDLE;
      tens     <= START_TENS;
      ones     <= START_ONES;
      tick_cnt <= '0;
      d1       <= map_d1(START_TENS);
      d0       <= START_ONES;
      running  <= 1'b0;
      expired  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !pause) begin
            tick_cnt <= '0;
            if (tens == 4'd0 && ones == 4'd0) begin
              state   <= EXPIRED;
              expired <= 1'b1;
            end else begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
        end
        RUN: begin
          if (pause) begin
            state   <= PAUSED;
            running <= 1'b0;
          end else if (tick_cnt == TICK_W'(TICK_DIV - 1)) begin
            tick_cnt <= '0;
            tens     <= dec_tens;
            ones     <= dec_ones;
            d1       <= map_d1(dec_tens);
            d0       <= dec_ones;
            if (dec_zero) begin
              state   <= EXPIRED;
              running <= 1'b0;
              expired <= 1'b1;
            end
          end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
          end
        end
        PAUSED: begin
          if (start && !pause) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shot_clock_bcd.sv
// Directed bench for shot_clock_bcd with TICK_DIV=10, SCAN_DIV=4, START=24.
module tb_shot_clock_bcd;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, pause = 1'b0, reload = 1'b0;
  logic [3:0] d1, d0;
  logic       scan_en, running, expired;
  int         checks = 0;
  int         failures = 0;
  logic [3:0] exp_tens_09;

  shot_clock_bcd #(
    .TICK_DIV(10), .SCAN_DIV(4), .START_TENS(4'd2), .START_ONES(4'd4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .reload(reload),
    .d1(d1), .d0(d0), .scan_en(scan_en), .running(running), .expired(expired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [3:0] t, input logic [3:0] o);
    chk({tag, "_d1"}, 32'(d1), 32'(t));
    chk({tag, "_d0"}, 32'(d0), 32'(o));
  endtask

  initial begin
`ifdef LEADING_ZERO_BLANK_EN
    exp_tens_09 = 4'hF;
`else
    exp_tens_09 = 4'd0;
`endif
    step(5);
    @(negedge clk);
    rst_n = 1'b1;
    chk_cnt("reset", 4'd2, 4'd4);
    chk("reset_running", 32'(running), 32'd0);
    chk("reset_expired", 32'(expired), 32'd0);
    chk("reset_scan_en", 32'(scan_en), 32'd0);

    for (int k = 1; k <= 8; k++) begin
      step(1);
      chk($sformatf("scan_en_%0d", k), 32'(scan_en), 32'((k % 4) == 0));
    end

    // countdown and expiry from 24
    start = 1'b1; step(1); start = 1'b0;
    chk("start_running", 32'(running), 32'd1);
    step(9);  chk_cnt("pre_tick1", 4'd2, 4'd4);
    step(1);  chk_cnt("tick1", 4'd2, 4'd3);
    step(39); chk_cnt("pre_borrow", 4'd2, 4'd0);
    step(1);  chk_cnt("borrow", 4'd1, 4'd9);
    step(189);
    chk_cnt("pre_expire", 4'd0, 4'd1);
    chk("pre_expire_exp", 32'(expired), 32'd0);
    step(1);
    chk("expire_d0", 32'(d0), 32'd0);
    chk("expire_exp", 32'(expired), 32'd1);
    chk("expire_run", 32'(running), 32'd0);
    step(100);
    chk("hold_d0", 32'(d0), 32'd0);
    chk("hold_exp", 32'(expired), 32'd1);

    start = 1'b1; step(1); start = 1'b0;
    chk("start_in_exp", 32'(expired), 32'd1);
    chk("start_in_exp_run", 32'(running), 32'd0);

    reload = 1'b1; step(1); reload = 1'b0;
    chk_cnt("reload", 4'd2, 4'd4);
    chk("reload_exp", 32'(expired), 32'd0);

    // priority while RUN at 13
    start = 1'b1; step(1); start = 1'b0;
    step(110);
    chk_cnt("at13", 4'd1, 4'd3);
    chk("at13_run", 32'(running), 32'd1);
    reload = 1'b1; pause = 1'b1; start = 1'b1; step(1);
    reload = 1'b0; pause = 1'b0; start = 1'b0;
    chk_cnt("prio", 4'd2, 4'd4);
    chk("prio_run", 32'(running), 32'd0);
    chk("prio_exp", 32'(expired), 32'd0);
    step(20);
    chk_cnt("idle_hold", 4'd2, 4'd4);

    // pause 5 cycles into a tick, then resume the partial tick
    start = 1'b1; step(1); start = 1'b0;
    step(5);
    pause = 1'b1; step(1); pause = 1'b0;
    chk("paused_run", 32'(running), 32'd0);
    step(30);
    chk_cnt("paused_hold", 4'd2, 4'd4);
    start = 1'b1; step(1); start = 1'b0;
    chk("resume_run", 32'(running), 32'd1);
    step(4); chk_cnt("resume_pre", 4'd2, 4'd4);
    step(1); chk_cnt("resume_dec", 4'd2, 4'd3);

    step(139); chk_cnt("at10", 4'd1, 4'd0);
    step(1);   chk_cnt("at09", exp_tens_09, 4'd9);

    // async reset mid-RUN
    #3 rst_n = 1'b0;
    #1;
    chk_cnt("async_rst", 4'd2, 4'd4);
    chk("async_rst_run", 32'(running), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
